trap_sequencer: RTL and testbench

- Sequences the five-stage pipeline through trap entry and trap return; sits beside the pipeline control unit.
- Detects EX-stage trap events (ebreak, PDU breakpoint, error codes), then:
  - drains older instructions;
  - flushes younger ones;
  - records mepc/mcause/mtval;
  - redirects fetch to a per-cause vector.
- On mret inside a handler, restores fetch to mepc.
- Owns the trap CSRs mtvec (0x305), mepc (0x341), mcause (0x342) and mtval (0x343).

---
 rtl/trap_sequencer_pkg.sv | 34 +++
 rtl/trap_csr_file.sv | 80 ++++++++
 rtl/trap_sequencer.sv | 185 ++++++++++++++++++
 tb/tb_trap_sequencer.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/trap_sequencer_pkg.sv
// Shared definitions for the trap sequencer: cause codes, CSR addresses,
// FSM state encodings and the vector-address helper.
package trap_sequencer_pkg;

   localparam int unsigned CAUSE_W_DEF       = 4;
   localparam logic [31:0] TRAP_BASE_DEFAULT = 32'h0000_F000;

   typedef enum logic [3:0] {
      No_Error            = 4'd0,
      Program_Breakpoint  = 4'd1,
      User_Breakpoint     = 4'd2,
      Divide_By_Zero      = 4'd3,
      Memory_Access_Error = 4'd4,
      Is_Decode_Error     = 4'd5
   } cause_e;

   localparam logic [11:0] CSR_MTVEC  = 12'h305;
   localparam logic [11:0] CSR_MEPC   = 12'h341;
   localparam logic [11:0] CSR_MCAUSE = 12'h342;
   localparam logic [11:0] CSR_MTVAL  = 12'h343;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_FLUSH  = 3'd1;
   localparam logic [2:0] ST_SAVE   = 3'd2;
   localparam logic [2:0] ST_VECTOR = 3'd3;
   localparam logic [2:0] ST_RETURN = 3'd4;

   // Each cause owns one 4-byte slot above mtvec, cause 1 at offset 0.
   function automatic logic [31:0] trap_vector(input logic [31:0] base,
                                               input logic [31:0] cause);
      trap_vector = base + ((cause - 32'd1) << 2);
   endfunction

endpackage

// File: rtl/trap_csr_file.sv
// Trap CSRs (mtvec, mepc, mcause, mtval) with a hardware save port that
// overrides same-cycle software writes, plus a combinational read mux.
module trap_csr_file
   import trap_sequencer_pkg::*;
#(
   parameter logic [31:0] TRAP_BASE = TRAP_BASE_DEFAULT
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        hw_we,
   input  logic [31:0] hw_epc,
   input  logic [31:0] hw_cause,
   input  logic [31:0] hw_tval,
   input  logic        sw_we,
   input  logic [11:0] sw_addr,
   input  logic [31:0] sw_wdata,
   input  logic [11:0] raddr,
   output logic [31:0] rdata,
   output logic [31:0] mtvec,
   output logic [31:0] mepc
);

   logic [31:0] mtvec_r;
   logic [31:0] mepc_r;
   logic [31:0] mcause_r;
   logic [31:0] mtval_r;
   logic        sw_mtvec_s;
   logic        sw_mepc_s;
   logic        sw_mcause_s;
   logic        sw_mtval_s;

   assign sw_mtvec_s  = sw_we && (sw_addr == CSR_MTVEC);
   assign sw_mepc_s   = sw_we && (sw_addr == CSR_MEPC);
   assign sw_mcause_s = sw_we && (sw_addr == CSR_MCAUSE);
   assign sw_mtval_s  = sw_we && (sw_addr == CSR_MTVAL);

   // mtvec: software-only, kept word aligned
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         mtvec_r <= {TRAP_BASE[31:2], 2'b00};
      end else if (sw_mtvec_s) begin
         mtvec_r <= {sw_wdata[31:2], 2'b00};
      end else begin
         mtvec_r <= mtvec_r;
      end
   end

   // mepc/mcause/mtval: hardware save has priority over software
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         mepc_r   <= 32'd0;
         mcause_r <= 32'd0;
         mtval_r  <= 32'd0;
      end else if (hw_we) begin
         mepc_r   <= hw_epc;
         mcause_r <= hw_cause;
         mtval_r  <= hw_tval;
      end else begin
         mepc_r   <= sw_mepc_s   ? sw_wdata : mepc_r;
         mcause_r <= sw_mcause_s ? sw_wdata : mcause_r;
         mtval_r  <= sw_mtval_s  ? sw_wdata : mtval_r;
      end
   end

   // read mux, unknown addresses read as zero
   always_comb begin
      rdata = 32'd0;
      case (raddr)
         CSR_MTVEC:  rdata = mtvec_r;
         CSR_MEPC:   rdata = mepc_r;
         CSR_MCAUSE: rdata = mcause_r;
         CSR_MTVAL:  rdata = mtval_r;
         default:    rdata = 32'd0;
      endcase
   end

   assign mtvec = mtvec_r;
   assign mepc  = mepc_r;

endmodule

// File: rtl/trap_sequencer.sv
// Trap entry/return sequencer: drains and flushes the pipeline on an EX trap,
// saves mepc/mcause/mtval, vectors fetch by cause, and returns to mepc on mret.
module trap_sequencer
   import trap_sequencer_pkg::*;
#(
   parameter logic [31:0] TRAP_BASE = TRAP_BASE_DEFAULT,
   parameter int unsigned CAUSE_W   = CAUSE_W_DEF
) (
   input  logic               clk,
   input  logic               rstn,
   input  logic               ebreak,
   input  logic               pdu_breakpoint,
   input  logic [CAUSE_W-1:0] error,
   input  logic               mret,
   input  logic [31:0]        ex_pc,
   input  logic [31:0]        ex_is,
   input  logic [31:0]        ex_mem_addr,
   input  logic               csr_we,
   input  logic [11:0]        csr_waddr,
   input  logic [31:0]        csr_wdata,
   input  logic [11:0]        csr_raddr,
   output logic [31:0]        csr_rdata,
   output logic               pipe_flush,
   output logic               pc_hold,
   output logic               pc_redirect,
   output logic [31:0]        redirect_pc,
   output logic               in_handler,
   output logic               lost_trap
);

   logic [2:0]         state_r;
   logic [2:0]         next_state_s;
   logic               trap_s;
   logic               take_trap_s;
   logic               lose_trap_s;
   logic [CAUSE_W-1:0] event_cause_s;
   logic [31:0]        event_epc_s;
   logic [31:0]        event_tval_s;
   logic [CAUSE_W-1:0] pend_cause_r;
   logic [31:0]        pend_epc_r;
   logic [31:0]        pend_tval_r;
   logic [31:0]        pend_cause_ext_s;
   logic               pipe_flush_r;
   logic               pc_hold_r;
   logic               pc_redirect_r;
   logic [31:0]        redirect_pc_r;
   logic               in_handler_r;
   logic               lost_trap_r;
   logic               hw_save_s;
   logic [31:0]        mtvec_s;
   logic [31:0]        mepc_s;

   assign trap_s           = ebreak || pdu_breakpoint || (error != {CAUSE_W{1'b0}});
   assign lose_trap_s      = (state_r == ST_IDLE) && trap_s && in_handler_r;
   assign hw_save_s        = (state_r == ST_SAVE);
   assign pend_cause_ext_s = {{(32-CAUSE_W){1'b0}}, pend_cause_r};

   // cause priority and epc/tval selection for the EX event
   always_comb begin
      event_cause_s = {CAUSE_W{1'b0}};
      event_epc_s   = ex_pc;
      event_tval_s  = 32'd0;
      if (ebreak) begin
         event_cause_s = CAUSE_W'(Program_Breakpoint);
         event_epc_s   = ex_pc + 32'd4;
         event_tval_s  = 32'd0;
      end else if (pdu_breakpoint) begin
         event_cause_s = CAUSE_W'(User_Breakpoint);
         event_epc_s   = ex_pc;
         event_tval_s  = ex_pc;
      end else begin
         event_cause_s = error;
         event_epc_s   = ex_pc;
         case (error)
            CAUSE_W'(Memory_Access_Error): event_tval_s = ex_mem_addr;
            CAUSE_W'(Is_Decode_Error):     event_tval_s = ex_is;
            default:                       event_tval_s = 32'd0;
         endcase
      end
   end

   // next-state logic; mret inside a handler outranks a new trap
   always_comb begin
      next_state_s = state_r;
      take_trap_s  = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (mret && in_handler_r) begin
               next_state_s = ST_RETURN;
            end else if (trap_s && !in_handler_r) begin
               next_state_s = ST_FLUSH;
               take_trap_s  = 1'b1;
            end else begin
               next_state_s = ST_IDLE;
            end
         end
         ST_FLUSH:  next_state_s = ST_SAVE;
         ST_SAVE:   next_state_s = ST_VECTOR;
         ST_VECTOR: next_state_s = ST_IDLE;
         ST_RETURN: next_state_s = ST_IDLE;
         default:   next_state_s = ST_IDLE;
      endcase
   end

   // state and pending trap record
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_r      <= ST_IDLE;
         pend_cause_r <= {CAUSE_W{1'b0}};
         pend_epc_r   <= 32'd0;
         pend_tval_r  <= 32'd0;
      end else if (take_trap_s) begin
         state_r      <= next_state_s;
         pend_cause_r <= event_cause_s;
         pend_epc_r   <= event_epc_s;
         pend_tval_r  <= event_tval_s;
      end else begin
         state_r      <= next_state_s;
      end
   end

   // outputs registered from the state being entered so they line up with it
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         pipe_flush_r  <= 1'b0;
         pc_hold_r     <= 1'b0;
         pc_redirect_r <= 1'b0;
         redirect_pc_r <= 32'd0;
      end else begin
         pipe_flush_r  <= (next_state_s != ST_IDLE);
         pc_hold_r     <= (next_state_s == ST_FLUSH) || (next_state_s == ST_SAVE);
         pc_redirect_r <= (next_state_s == ST_VECTOR) || (next_state_s == ST_RETURN);
         if (next_state_s == ST_VECTOR) begin
            redirect_pc_r <= trap_vector(mtvec_s, pend_cause_ext_s);
         end else if (next_state_s == ST_RETURN) begin
            redirect_pc_r <= mepc_s;
         end else begin
            redirect_pc_r <= 32'd0;
         end
      end
   end

   // handler residency and sticky dropped-trap flag
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         in_handler_r <= 1'b0;
         lost_trap_r  <= 1'b0;
      end else begin
         if (hw_save_s) begin
            in_handler_r <= 1'b1;
         end else if (next_state_s == ST_RETURN) begin
            in_handler_r <= 1'b0;
         end else begin
            in_handler_r <= in_handler_r;
         end
         lost_trap_r <= lost_trap_r || lose_trap_s;
      end
   end

   trap_csr_file #(
      .TRAP_BASE (TRAP_BASE)
   ) u_csr (
      .clk      (clk),
      .rstn     (rstn),
      .hw_we    (hw_save_s),
      .hw_epc   (pend_epc_r),
      .hw_cause (pend_cause_ext_s),
      .hw_tval  (pend_tval_r),
      .sw_we    (csr_we),
      .sw_addr  (csr_waddr),
      .sw_wdata (csr_wdata),
      .raddr    (csr_raddr),
      .rdata    (csr_rdata),
      .mtvec    (mtvec_s),
      .mepc     (mepc_s)
   );

   assign pipe_flush  = pipe_flush_r;
   assign pc_hold     = pc_hold_r;
   assign pc_redirect = pc_redirect_r;
   assign redirect_pc = redirect_pc_r;
   assign in_handler  = in_handler_r;
   assign lost_trap   = lost_trap_r;

endmodule

// File: tb/tb_trap_sequencer.sv
// Self-checking bench: directed scenarios plus randomized traffic compared
// cycle by cycle against a queue-based reference model of trap sequencing.
module tb_trap_sequencer;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic        ebreak = 1'b0;
   logic        pdu_breakpoint = 1'b0;
   logic [3:0]  error = 4'd0;
   logic        mret = 1'b0;
   logic [31:0] ex_pc = 32'd0;
   logic [31:0] ex_is = 32'd0;
   logic [31:0] ex_mem_addr = 32'd0;
   logic        csr_we = 1'b0;
   logic [11:0] csr_waddr = 12'd0;
   logic [31:0] csr_wdata = 32'd0;
   logic [11:0] csr_raddr = 12'd0;
   logic [31:0] csr_rdata;
   logic        pipe_flush;
   logic        pc_hold;
   logic        pc_redirect;
   logic [31:0] redirect_pc;
   logic        in_handler;
   logic        lost_trap;

   trap_sequencer dut (
      .clk            (clk),
      .rstn           (rstn),
      .ebreak         (ebreak),
      .pdu_breakpoint (pdu_breakpoint),
      .error          (error),
      .mret           (mret),
      .ex_pc          (ex_pc),
      .ex_is          (ex_is),
      .ex_mem_addr    (ex_mem_addr),
      .csr_we         (csr_we),
      .csr_waddr      (csr_waddr),
      .csr_wdata      (csr_wdata),
      .csr_raddr      (csr_raddr),
      .csr_rdata      (csr_rdata),
      .pipe_flush     (pipe_flush),
      .pc_hold        (pc_hold),
      .pc_redirect    (pc_redirect),
      .redirect_pc    (redirect_pc),
      .in_handler     (in_handler),
      .lost_trap      (lost_trap)
   );

   always #5 clk = ~clk;

   int tests_run = 0;
   int tests_failed = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
      end
   endtask

   // reference model: one entry per cycle of an active sequence
   typedef struct {
      bit          active;
      bit          flush;
      bit          hold;
      bit          redir;
      bit          save;
      bit          vec;
      logic [31:0] rpc;
   } exp_t;

   exp_t        q[$];
   exp_t        cur;
   logic [31:0] m_mtvec, m_mepc, m_mcause, m_mtval;
   logic [31:0] p_epc, p_tval, p_cause;
   bit          m_inh, m_lost;

   function automatic exp_t mk(bit f, bit h, bit r, bit s, bit v, logic [31:0] pc);
      exp_t e;
      e.active = 1'b1; e.flush = f; e.hold = h; e.redir = r;
      e.save = s; e.vec = v; e.rpc = pc;
      return e;
   endfunction

   task automatic model_reset();
      q.delete();
      cur = '{default: 0};
      m_mtvec = 32'h0000_F000;
      m_mepc = 32'd0; m_mcause = 32'd0; m_mtval = 32'd0;
      p_epc = 32'd0; p_tval = 32'd0; p_cause = 32'd0;
      m_inh = 1'b0; m_lost = 1'b0;
   endtask

   task automatic model_edge();
      bit          trap;
      logic [31:0] old_mtvec;
      old_mtvec = m_mtvec;
      trap = ebreak || pdu_breakpoint || (error != 4'd0);
      if (!cur.active) begin
         if (mret && m_inh) begin
            q.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, m_mepc));
            m_inh = 1'b0;
            if (trap) m_lost = 1'b1;
         end else if (trap && m_inh) begin
            m_lost = 1'b1;
         end else if (trap) begin
            p_epc = ex_pc;
            p_tval = 32'd0;
            if (ebreak) begin
               p_cause = 32'd1; p_epc = ex_pc + 32'd4;
            end else if (pdu_breakpoint) begin
               p_cause = 32'd2; p_tval = ex_pc;
            end else begin
               p_cause = {28'd0, error};
               if (error == 4'd4) p_tval = ex_mem_addr;
               if (error == 4'd5) p_tval = ex_is;
            end
            q.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0));
            q.push_back(mk(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'd0));
            q.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'd0));
         end
      end
      if (cur.save) begin
         m_mepc = p_epc; m_mcause = p_cause; m_mtval = p_tval; m_inh = 1'b1;
      end
      if (csr_we) begin
         if (csr_waddr == 12'h305) m_mtvec = {csr_wdata[31:2], 2'b00};
         if (csr_waddr == 12'h341 && !cur.save) m_mepc = csr_wdata;
         if (csr_waddr == 12'h342 && !cur.save) m_mcause = csr_wdata;
         if (csr_waddr == 12'h343 && !cur.save) m_mtval = csr_wdata;
      end
      if (q.size() > 0) begin
         cur = q.pop_front();
         if (cur.vec) cur.rpc = old_mtvec + (p_cause - 32'd1) * 32'd4;
      end else begin
         cur = '{default: 0};
      end
   endtask

   function automatic logic [31:0] model_csr(input logic [11:0] a);
      case (a)
         12'h305: return m_mtvec;
         12'h341: return m_mepc;
         12'h342: return m_mcause;
         12'h343: return m_mtval;
         default: return 32'd0;
      endcase
   endfunction

   task automatic compare_all();
      check("pipe_flush",  {31'd0, pipe_flush},  {31'd0, cur.flush});
      check("pc_hold",     {31'd0, pc_hold},     {31'd0, cur.hold});
      check("pc_redirect", {31'd0, pc_redirect}, {31'd0, cur.redir});
      check("redirect_pc", redirect_pc, cur.redir ? cur.rpc : 32'd0);
      check("in_handler",  {31'd0, in_handler},  {31'd0, m_inh});
      check("lost_trap",   {31'd0, lost_trap},   {31'd0, m_lost});
      check("csr_rdata",   csr_rdata, model_csr(csr_raddr));
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      compare_all();
   endtask

   task automatic idle_inputs();
      ebreak = 1'b0; pdu_breakpoint = 1'b0; error = 4'd0; mret = 1'b0; csr_we = 1'b0;
   endtask

   task automatic read_csr(input string tag, input logic [11:0] a, input logic [31:0] exp);
      csr_raddr = a;
      #1;
      check(tag, csr_rdata, exp);
   endtask

   // enter a trap from idle and run to the first handler cycle
   task automatic run_trap(input string tag, input logic [31:0] exp_vec);
      step(); idle_inputs();
      check({tag, "_flush1"}, {31'd0, pipe_flush}, 32'd1);
      step();
      step();
      check({tag, "_flush3"}, {31'd0, pipe_flush}, 32'd1);
      check({tag, "_redir"}, {31'd0, pc_redirect}, 32'd1);
      check({tag, "_vec"}, redirect_pc, exp_vec);
      step();
      check({tag, "_inh"}, {31'd0, in_handler}, 32'd1);
   endtask

   task automatic do_mret();
      mret = 1'b1;
      step(); idle_inputs();
      step();
   endtask

   initial begin
      model_reset();
      #12;
      compare_all();
      read_csr("rst_mtvec", 12'h305, 32'h0000_F000);
      read_csr("rst_mepc", 12'h341, 32'd0);
      @(negedge clk);
      rstn = 1'b1;

      // ebreak at 0x100
      ebreak = 1'b1; ex_pc = 32'h100;
      run_trap("ebrk", 32'h0000_F000);
      read_csr("ebrk_mepc", 12'h341, 32'h104);
      read_csr("ebrk_mcause", 12'h342, 32'd1);
      read_csr("ebrk_mtval", 12'h343, 32'd0);
      do_mret();

      // pdu breakpoint beats divide-by-zero
      pdu_breakpoint = 1'b1; error = 4'd3; ex_pc = 32'h200;
      run_trap("pdu", 32'h0000_F004);
      read_csr("pdu_mcause", 12'h342, 32'd2);
      read_csr("pdu_mtval", 12'h343, 32'h200);
      do_mret();

      // memory access error
      error = 4'd4; ex_pc = 32'h40; ex_mem_addr = 32'hDEAD_BEE0;
      run_trap("mem", 32'h0000_F00C);
      read_csr("mem_mepc", 12'h341, 32'h40);
      read_csr("mem_mtval", 12'h343, 32'hDEAD_BEE0);

      // software mepc rewrite, then mret
      csr_we = 1'b1; csr_waddr = 12'h341; csr_wdata = 32'h300;
      step(); idle_inputs();
      mret = 1'b1;
      step(); idle_inputs();
      check("ret_redir", {31'd0, pc_redirect}, 32'd1);
      check("ret_pc", redirect_pc, 32'h300);
      check("ret_inh", {31'd0, in_handler}, 32'd0);
      step();

      // error and mret together inside a handler
      ebreak = 1'b1; ex_pc = 32'h500;
      run_trap("e2", 32'h0000_F000);
      error = 4'd5; mret = 1'b1; ex_is = 32'h1234_5678;
      step(); idle_inputs();
      check("both_redir", {31'd0, pc_redirect}, 32'd1);
      check("both_lost", {31'd0, lost_trap}, 32'd1);
      read_csr("both_mcause", 12'h342, 32'd1);
      step();

      // reset during SAVE
      ebreak = 1'b1; ex_pc = 32'h600;
      step(); idle_inputs();
      step();
      #2;
      rstn = 1'b0;
      #1;
      model_reset();
      compare_all();
      read_csr("rs_mtvec", 12'h305, 32'h0000_F000);
      read_csr("rs_mepc", 12'h341, 32'd0);
      @(negedge clk);
      rstn = 1'b1;
      ebreak = 1'b1; ex_pc = 32'h700;
      run_trap("post_rst", 32'h0000_F000);
      do_mret();

      // randomized traffic
      for (int i = 0; i < 2000; i++) begin
         logic [11:0] addrs [6];
         addrs[0] = 12'h305; addrs[1] = 12'h341; addrs[2] = 12'h342;
         addrs[3] = 12'h343; addrs[4] = 12'h300; addrs[5] = 12'($urandom);
         ebreak         = ($urandom_range(15) == 0);
         pdu_breakpoint = ($urandom_range(15) == 0);
         error          = ($urandom_range(11) == 0) ? 4'($urandom_range(15, 1)) : 4'd0;
         mret           = m_inh ? ($urandom_range(7) == 0) : ($urandom_range(29) == 0);
         ex_pc          = $urandom;
         ex_is          = $urandom;
         ex_mem_addr    = $urandom;
         csr_we         = ($urandom_range(7) == 0);
         csr_waddr      = addrs[$urandom_range(5)];
         csr_wdata      = $urandom;
         csr_raddr      = addrs[$urandom_range(5)];
         step();
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
